// File: rtl/mem_bram_responder.sv
// mem_bram_responder
//   Block-RAM stand-in for the DDR2 wrapper on the clk_cpu RAM transaction
//   interface. Each accepted strobe completes a fixed LATENCY cycles later,
//   so initiators see a realistic, configurable memory delay.
//
// Ports
//   clk_cpu              CPU clock, rising edge
//   rst_n                asynchronous active-low reset
//   addr[27:0]           byte address; bits above WORDS_LOG2+2 are ignored (alias)
//   width[1:0]           00=8, 01=16, 10=32, 11=64 bits
//   data_in[63:0]        write data, right-justified
//   rstrobe / wstrobe    single-cycle read / write request, sampled while ready=1
//   data_out[63:0]       read data, right-justified, zero-extended, held between reads
//   transaction_complete one-cycle pulse when the accepted transaction finishes
//   ready                high when a new strobe can be accepted
//   err                  one-cycle pulse on both strobes together or a misaligned request
//   drop_count[7:0]      saturating count of strobes seen while ready=0
module mem_bram_responder #(
  parameter int unsigned LATENCY    = 8,
  parameter int unsigned WORDS_LOG2 = 10
) (
  input  logic        clk_cpu,
  input  logic        rst_n,
  input  logic [27:0] addr,
  input  logic [1:0]  width,
  input  logic [63:0] data_in,
  input  logic        rstrobe,
  input  logic        wstrobe,
  output logic [63:0] data_out,
  output logic        transaction_complete,
  output logic        ready,
  output logic        err,
  output logic [7:0]  drop_count
);

  localparam int unsigned AddrW   = WORDS_LOG2 + 3;
  localparam int unsigned Words   = 1 << WORDS_LOG2;
  localparam logic [7:0]  LatInit = 8'(LATENCY - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [WORDS_LOG2-1:0] idx_q, idx_d;
  logic [2:0]            lane_q, lane_d;
  logic [1:0]            width_q, width_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [63:0]           data_out_q, data_out_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [7:0]            drop_q, drop_d;

  logic [63:0] mem_q [Words];

  // Upper address bits alias; they are intentionally not decoded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[27:AddrW];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [2:0]            low_mask;
  logic                  misaligned;
  logic [2:0]            lane_in;
  logic [WORDS_LOG2-1:0] idx_in;
  logic                  accept;
  logic                  both;

  always_comb begin
    low_mask = 3'b000;
    unique case (width)
      2'b00: low_mask = 3'b000;
      2'b01: low_mask = 3'b001;
      2'b10: low_mask = 3'b011;
      2'b11: low_mask = 3'b111;
      default: low_mask = 3'b000;
    endcase
  end

  assign misaligned = |(addr[2:0] & low_mask);
  assign lane_in    = addr[2:0] & ~low_mask;
  assign idx_in     = addr[AddrW-1:3];
  assign accept     = ready_q & (rstrobe ^ wstrobe);
  assign both       = ready_q & rstrobe & wstrobe;

  // ---------------------------------------------------------------------------
  // Read path: lane select from the word the FSM is about to complete
  // ---------------------------------------------------------------------------
  logic [63:0] rd_word, rd_shift, rd_mask;

  always_comb begin
    rd_word  = mem_q[idx_d];
    rd_shift = rd_word >> {lane_d, 3'b000};
    rd_mask  = '1;
    unique case (width_d)
      2'b00: rd_mask = 64'h0000_0000_0000_00FF;
      2'b01: rd_mask = 64'h0000_0000_0000_FFFF;
      2'b10: rd_mask = 64'h0000_0000_FFFF_FFFF;
      2'b11: rd_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      default: rd_mask = '1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write path: byte-enable commit during DONE
  // ---------------------------------------------------------------------------
  logic [7:0]  be_base, be;
  logic [63:0] wshift;
  logic        we;

  always_comb begin
    be_base = 8'h00;
    unique case (width_q)
      2'b00: be_base = 8'h01;
      2'b01: be_base = 8'h03;
      2'b10: be_base = 8'h0F;
      2'b11: be_base = 8'hFF;
      default: be_base = 8'h00;
    endcase
  end

  assign be     = be_base << lane_q;
  assign wshift = wdata_q << {lane_q, 3'b000};
  assign we     = (state_q == StDone) & op_wr_q;

  // Storage has no reset so contents survive rst_n.
  always_ff @(posedge clk_cpu) begin
    if (we) begin
      for (int k = 0; k < 8; k++) begin
        if (be[k]) mem_q[idx_q][8*k +: 8] <= wshift[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_wr_d    = op_wr_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    width_d    = width_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    err_d      = both | (accept & misaligned);
    drop_d     = drop_q;

    if (!ready_q && (rstrobe || wstrobe) && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    case (state_q)
      StIdle: begin
        if (accept) begin
          op_wr_d = wstrobe;
          idx_d   = idx_in;
          lane_d  = lane_in;
          width_d = width;
          wdata_d = data_in;
          cnt_d   = LatInit;
          state_d = (LATENCY == 1) ? StDone : StBusy;
        end
      end
      StBusy: begin
        // Leave BUSY on the edge where the counter reaches zero.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Register read data on the edge entering DONE so it lines up with the pulse.
    if (state_d == StDone && state_q != StDone && !op_wr_d) begin
      data_out_d = rd_shift & rd_mask;
    end

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      op_wr_q    <= 1'b0;
      idx_q      <= '0;
      lane_q     <= 3'd0;
      width_q    <= 2'd0;
      wdata_q    <= 64'd0;
      data_out_q <= 64'd0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_wr_q    <= op_wr_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      width_q    <= width_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
    end
  end

  assign data_out             = data_out_q;
  assign transaction_complete = (state_q == StDone);
  assign ready                = ready_q;
  assign err                  = err_q;
  assign drop_count           = drop_q;

endmodule
